i2c_bus_arbiter: RTL and testbench

- Shares one I2C master core (FSM plus SCL generator) between two independent requesters.
- Accepts single-byte read/write commands on a req/gnt handshake and arbitrates round-robin.
- Launches the winning command on the master, supervises completion with a timeout, and returns status and read data to the winner.
- Enforces a minimum bus-free gap between transactions.

---
 rtl/i2c_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Two-requester round-robin front end for a shared I2C master core.
// Launches one command at a time, supervises it with a timeout, enforces bus-free gap.
module i2c_bus_arbiter #(
   parameter int ADDR_LEN = 7,
   parameter int DATA_LEN = 8,
   parameter int TIMEOUT  = 1000,
   parameter int BUS_FREE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0,
   input  logic                req1,
   input  logic                rd_wr0,
   input  logic                rd_wr1,
   input  logic [ADDR_LEN-1:0] addr0,
   input  logic [ADDR_LEN-1:0] addr1,
   input  logic [DATA_LEN-1:0] wdata0,
   input  logic [DATA_LEN-1:0] wdata1,
   output logic                gnt0,
   output logic                gnt1,
   output logic                done0,
   output logic                done1,
   output logic                err,
   output logic [DATA_LEN-1:0] rdata,
   output logic                busy,
   output logic                m_start,
   output logic                m_abort,
   output logic                m_rd_wr,
   output logic [ADDR_LEN-1:0] m_addr,
   output logic [DATA_LEN-1:0] m_wdata,
   input  logic                m_done,
   input  logic                m_nack,
   input  logic [DATA_LEN-1:0] m_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;

   localparam logic [15:0] T_LAST = 16'(TIMEOUT - 1);
   localparam logic [15:0] G_LAST = 16'(BUS_FREE - 1);

   logic [1:0]  state;
   logic        owner;
   logic        last_gnt;
   logic [15:0] tcnt;
   logic [15:0] gcnt;
   logic        any_req;
   logic        winner;

   // On a tie the requester that did not win last time goes first
   assign any_req = req0 | req1;
   assign winner  = (req0 & req1) ? ~last_gnt : req1;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last_gnt <= 1'b1;
         tcnt     <= '0;
         gcnt     <= '0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         err      <= 1'b0;
         rdata    <= '0;
         m_start  <= 1'b0;
         m_abort  <= 1'b0;
         m_rd_wr  <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
      end else begin
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         m_start <= 1'b0;
         m_abort <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner    <= winner;
                  last_gnt <= winner;
                  gnt0     <= ~winner;
                  gnt1     <= winner;
                  m_rd_wr  <= winner ? rd_wr1 : rd_wr0;
                  m_addr   <= winner ? addr1 : addr0;
                  m_wdata  <= winner ? wdata1 : wdata0;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               m_start <= 1'b1;
               tcnt    <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               tcnt <= tcnt + 16'd1;
               // A completion on the timeout cycle still counts as a completion
               if (m_done) begin
                  done0 <= ~owner;
                  done1 <= owner;
                  err   <= m_nack;
                  if (m_rd_wr)
                     rdata <= m_rdata;
                  gcnt  <= '0;
                  state <= GAP;
               end else if (tcnt == T_LAST) begin
                  done0   <= ~owner;
                  done1   <= owner;
                  err     <= 1'b1;
                  m_abort <= 1'b1;
                  gcnt    <= '0;
                  state   <= GAP;
               end
            end
            GAP: begin
               if (gcnt == G_LAST)
                  state <= IDLE;
               else
                  gcnt <= gcnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: grant/launch timing, round-robin,
// read return, nack, timeout boundary, bus-free gap and mid-transaction reset.
module tb_i2c_bus_arbiter;

   localparam int TO = 32;
   localparam int BF = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       rd_wr0 = 1'b0, rd_wr1 = 1'b0;
   logic [6:0] addr0 = '0, addr1 = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic       gnt0, gnt1, done0, done1, err, busy;
   logic [7:0] rdata;
   logic       m_start, m_abort, m_rd_wr;
   logic [6:0] m_addr;
   logic [7:0] m_wdata;
   logic       m_done = 1'b0, m_nack = 1'b0;
   logic [7:0] m_rdata = '0;

   int checks = 0;
   int errors = 0;

   i2c_bus_arbiter #(
      .ADDR_LEN(7), .DATA_LEN(8), .TIMEOUT(TO), .BUS_FREE(BF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1),
      .rd_wr0(rd_wr0), .rd_wr1(rd_wr1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .done0(done0), .done1(done1),
      .err(err), .rdata(rdata), .busy(busy),
      .m_start(m_start), .m_abort(m_abort),
      .m_rd_wr(m_rd_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // lat = cycles from m_start to m_done; lat==0 means m_done never comes
   task automatic run_cmd(input logic who, input logic rd,
                          input logic [6:0] a, input logic [7:0] wd,
                          input int lat, input logic nack,
                          input logic [7:0] mrd, input logic [7:0] exp_rd,
                          input logic exp_err);
      if (who) begin
         req1 = 1'b1; rd_wr1 = rd; addr1 = a; wdata1 = wd;
      end else begin
         req0 = 1'b1; rd_wr0 = rd; addr0 = a; wdata0 = wd;
      end
      tick();
      check("gnt", 32'({gnt1, gnt0}), who ? 32'd2 : 32'd1);
      check("busy_gnt", 32'(busy), 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      check("m_start", 32'(m_start), 32'd1);
      check("m_cmd", 32'({m_rd_wr, m_addr, m_wdata}), 32'({rd, a, wd}));
      for (int i = 1; i < ((lat == 0) ? TO : lat); i++) begin
         tick();
         check("early", 32'({m_start, m_abort, done1, done0}), 32'd0);
      end
      if (lat != 0) begin
         tick();
         m_done = 1'b1; m_nack = nack; m_rdata = mrd;
      end
      tick();
      m_done = 1'b0;
      m_nack = 1'b0;
      check("done", 32'({done1, done0}), who ? 32'd2 : 32'd1);
      check("err", 32'(err), 32'(exp_err));
      check("rdata", 32'(rdata), 32'(exp_rd));
      check("abort", 32'(m_abort), (lat == 0) ? 32'd1 : 32'd0);
      for (int i = 1; i < BF; i++) begin
         tick();
         check("gap_busy", 32'(busy), 32'd1);
         check("gap_quiet", 32'({done1, done0, m_abort, gnt1, gnt0}), 32'd0);
      end
      tick();
      check("idle", 32'(busy), 32'd0);
   endtask

   initial begin
      int         n;
      int         mcnt;
      logic       exp_who;

      tick();
      tick();
      check("rst_ctl", 32'({gnt0, gnt1, done0, done1, err, busy,
                            m_start, m_abort, m_rd_wr}), 32'd0);
      check("rst_data", 32'({rdata, m_addr, m_wdata}), 32'd0);
      rst_n = 1'b1;
      tick();

      // single write, m_done 20 cycles after m_start
      run_cmd(1'b0, 1'b0, 7'h50, 8'hA5, 20, 1'b0, 8'h00, 8'h00, 1'b0);
      // read from requester 1
      run_cmd(1'b1, 1'b1, 7'h3C, 8'h00, 5, 1'b0, 8'h5A, 8'h5A, 1'b0);

      // both requesting continuously: grants must alternate from 0
      req0 = 1'b1; rd_wr0 = 1'b0; addr0 = 7'h01; wdata0 = 8'h11;
      req1 = 1'b1; rd_wr1 = 1'b0; addr1 = 7'h02; wdata1 = 8'h22;
      n = 0;
      mcnt = 0;
      exp_who = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (n == 4 && !busy && !m_done && mcnt == 0) break;
         tick();
         if (m_done) m_done = 1'b0;
         check("excl", 32'({gnt0 & gnt1, done0 & done1}), 32'd0);
         if (m_start) mcnt = 3;
         else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) m_done = 1'b1;
         end
         if (gnt0 | gnt1) begin
            check("rr", 32'(gnt1), 32'(exp_who));
            exp_who = ~exp_who;
            n++;
            if (n == 4) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end else if (gnt1) addr1 = addr1 + 7'd1;
            else addr0 = addr0 + 7'd1;
         end
      end
      check("rr_count", 32'(n), 32'd4);
      check("rr_idle", 32'(busy), 32'd0);
      check("rr_rdata", 32'(rdata), 32'h5A);

      // nacked write: err set, rdata held
      run_cmd(1'b0, 1'b0, 7'h12, 8'h34, 3, 1'b1, 8'hFF, 8'h5A, 1'b1);
      // m_done on the last timeout cycle wins, no abort
      run_cmd(1'b1, 1'b0, 7'h13, 8'h35, TO - 1, 1'b0, 8'hEE, 8'h5A, 1'b0);
      // no m_done at all: abort after TO cycles, read data untouched
      run_cmd(1'b0, 1'b1, 7'h14, 8'h36, 0, 1'b0, 8'h00, 8'h5A, 1'b1);

      // reset while waiting on the master
      req0 = 1'b1; rd_wr0 = 1'b1; addr0 = 7'h11; wdata0 = 8'h77;
      tick();
      req0 = 1'b0;
      tick();
      tick();
      tick();
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_ctl", 32'({gnt0, gnt1, done0, done1, err, busy,
                                m_start, m_abort, m_rd_wr}), 32'd0);
      check("mid_rst_data", 32'({rdata, m_addr, m_wdata}), 32'd0);
      for (int i = 0; i < TO + 8; i++) begin
         tick();
         check("post_rst_quiet", 32'({done1, done0, m_abort, busy}), 32'd0);
      end
      run_cmd(1'b0, 1'b1, 7'h22, 8'h00, 6, 1'b0, 8'h3C, 8'h3C, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
